// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants and types for the decode/control pipeline.
//   ALUOP_*    : 4-bit ALU operation encodings
//   OP_* / FN_*: primary opcode and function-field values of the supported subset
//   ctrl_t     : packed control bundle produced by the decoder
package ctrl_pkg;

  localparam logic [3:0] ALUOP_ADD  = 4'b0000;
  localparam logic [3:0] ALUOP_SUB  = 4'b0001;
  localparam logic [3:0] ALUOP_MUL  = 4'b0010;
  localparam logic [3:0] ALUOP_AND  = 4'b0011;
  localparam logic [3:0] ALUOP_OR   = 4'b0100;
  localparam logic [3:0] ALUOP_SLT  = 4'b0101;
  localparam logic [3:0] ALUOP_BNE  = 4'b0111;
  localparam logic [3:0] ALUOP_SLL  = 4'b1000;
  localparam logic [3:0] ALUOP_SRL  = 4'b1001;
  localparam logic [3:0] ALUOP_ROTR = 4'b1010;
  localparam logic [3:0] ALUOP_CLO  = 4'b1011;
  localparam logic [3:0] ALUOP_CLZ  = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_SPEC2 = 6'b011100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_ROTR = 6'b000110;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_CLO  = 6'b100001;
  localparam logic [5:0] FN_CLZ  = 6'b100000;
  localparam logic [5:0] FN_MUL  = 6'b000010;

  typedef struct packed {
    logic       alu_src;
    logic       alu_src2;
    logic       reg_sl;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       brnch;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/ctrl_decode_comb.sv
// ctrl_decode_comb: purely combinational main decoder.
//   op, fn   : instr[31:26] and instr[5:0]
//   ctrl     : decoded control bundle (all zero for undecodable words)
//   uses_rs  : instruction reads the rs field
//   uses_rt  : instruction reads the rt field
//   illegal  : op/fn combination is not in the supported subset
module ctrl_decode_comb
  import ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] fn,
  output ctrl_t      ctrl,
  output logic       uses_rs,
  output logic       uses_rt,
  output logic       illegal
);

  always_comb begin
    ctrl    = '0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        uses_rs        = 1'b1;
        uses_rt        = 1'b1;
        case (fn)
          FN_ADD:  ctrl.alu_op = ALUOP_ADD;
          FN_SUB:  ctrl.alu_op = ALUOP_SUB;
          FN_AND:  ctrl.alu_op = ALUOP_AND;
          FN_OR:   ctrl.alu_op = ALUOP_OR;
          FN_SLT:  ctrl.alu_op = ALUOP_SLT;
          FN_ROTR: ctrl.alu_op = ALUOP_ROTR;
          FN_SLL, FN_SRL: begin
            // Immediate shifts take their amount from shamt, so rs is not read.
            ctrl.alu_op   = (fn == FN_SLL) ? ALUOP_SLL : ALUOP_SRL;
            ctrl.alu_src2 = 1'b1;
            ctrl.reg_sl   = 1'b1;
            uses_rs       = 1'b0;
          end
          default: begin
            ctrl    = '0;
            uses_rs = 1'b0;
            uses_rt = 1'b0;
            illegal = 1'b1;
          end
        endcase
      end
      OP_SPEC2: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        uses_rs        = 1'b1;
        uses_rt        = 1'b1;
        case (fn)
          FN_CLO:  ctrl.alu_op = ALUOP_CLO;
          FN_CLZ:  ctrl.alu_op = ALUOP_CLZ;
          FN_MUL:  ctrl.alu_op = ALUOP_MUL;
          default: begin
            ctrl    = '0;
            uses_rs = 1'b0;
            uses_rt = 1'b0;
            illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ORI: begin
        ctrl.alu_op    = (op == OP_ADDI) ? ALUOP_ADD : ALUOP_OR;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        uses_rs        = 1'b1;
      end
      OP_LW: begin
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        uses_rs         = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        uses_rs        = 1'b1;
        uses_rt        = 1'b1;
      end
      OP_BNE: begin
        ctrl.alu_op  = ALUOP_BNE;
        ctrl.reg_dst = 1'b1;
        ctrl.brnch   = 1'b1;
        uses_rs      = 1'b1;
        uses_rt      = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: registered decode stage between IF/ID and execute.
//   in_valid/in_ready/instr : upstream handshake and instruction word
//   flush                   : squash the output register and load-hazard state
//   out_valid/out_ready     : downstream handshake for the control bundle
//   alu_src .. brnch, alu_op: registered control bundle
//   wr_addr                 : resolved destination (rd when reg_dst, else rt)
//   illegal                 : bundle came from an undecodable instruction
//   perf_stall              : saturating count of cycles a hazard blocked input
module decode_ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int ALUOP_W    = 4,
  parameter int LOAD_STALL = 1,
  parameter int PERF_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               alu_src,
  output logic               alu_src2,
  output logic               reg_sl,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               brnch,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [REG_AW-1:0]  wr_addr,
  output logic               illegal,
  output logic [PERF_W-1:0]  perf_stall
);

  logic [REG_AW-1:0] rs_f, rt_f, rd_f;
  ctrl_t             dec_ctrl;
  logic              dec_uses_rs, dec_uses_rt, dec_illegal;
  logic              hazard, accept, is_lw;
  logic [REG_AW-1:0] wr_addr_next;

  logic              out_valid_reg;
  ctrl_t             ctrl_reg;
  logic              illegal_reg;
  logic [REG_AW-1:0] wr_addr_reg;
  logic [1:0]        ld_age_reg;
  logic [REG_AW-1:0] ld_dest_reg;
  logic [PERF_W-1:0] perf_reg;

  // Register fields are zero-extended or truncated to REG_AW.
  for (genvar gi = 0; gi < REG_AW; gi++) begin : g_field
    if (gi < 5) begin : g_bit
      assign rs_f[gi] = instr[21+gi];
      assign rt_f[gi] = instr[16+gi];
      assign rd_f[gi] = instr[11+gi];
    end else begin : g_pad
      assign rs_f[gi] = 1'b0;
      assign rt_f[gi] = 1'b0;
      assign rd_f[gi] = 1'b0;
    end
  end

  // shamt is consumed by the execute stage from its own copy of the word.
  logic unused_shamt;
  assign unused_shamt = ^instr[10:6];

  ctrl_decode_comb u_dec (
    .op      (instr[31:26]),
    .fn      (instr[5:0]),
    .ctrl    (dec_ctrl),
    .uses_rs (dec_uses_rs),
    .uses_rt (dec_uses_rt),
    .illegal (dec_illegal)
  );

  always_comb begin
    hazard = in_valid && (ld_age_reg != 2'd0) && (ld_dest_reg != '0) &&
             ((dec_uses_rs && (rs_f == ld_dest_reg)) ||
              (dec_uses_rt && (rt_f == ld_dest_reg)));
    in_ready     = !flush && !hazard && (!out_valid_reg || out_ready);
    accept       = in_valid && in_ready;
    is_lw        = (instr[31:26] == OP_LW);
    wr_addr_next = dec_ctrl.reg_dst ? rd_f : rt_f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      ctrl_reg      <= '0;
      illegal_reg   <= 1'b0;
      wr_addr_reg   <= '0;
      ld_age_reg    <= 2'd0;
      ld_dest_reg   <= '0;
      perf_reg      <= '0;
    end else begin
      if (flush || !(out_valid_reg && !out_ready)) begin
        // Either squashed, a new bundle loaded, or a zeroed bubble;
        // a stalled valid bundle skips this and holds.
        out_valid_reg <= accept;
        ctrl_reg      <= accept ? dec_ctrl     : '0;
        illegal_reg   <= accept ? dec_illegal  : 1'b0;
        wr_addr_reg   <= accept ? wr_addr_next : '0;
      end

      if (flush) begin
        ld_age_reg <= 2'd0;
      end else if (accept && is_lw && (rt_f != '0)) begin
        ld_dest_reg <= rt_f;
        ld_age_reg  <= 2'(LOAD_STALL);
      end else if ((ld_age_reg != 2'd0) && (!out_valid_reg || out_ready)) begin
        // Age only advances when the pipe moves, so a downstream stall
        // does not eat into the load-use bubble.
        ld_age_reg <= ld_age_reg - 2'd1;
      end

      if (hazard && (perf_reg != '1)) begin
        perf_reg <= perf_reg + 1'b1;
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign alu_src    = ctrl_reg.alu_src;
  assign alu_src2   = ctrl_reg.alu_src2;
  assign reg_sl     = ctrl_reg.reg_sl;
  assign reg_dst    = ctrl_reg.reg_dst;
  assign reg_write  = ctrl_reg.reg_write;
  assign mem_read   = ctrl_reg.mem_read;
  assign mem_write  = ctrl_reg.mem_write;
  assign mem_to_reg = ctrl_reg.mem_to_reg;
  assign brnch      = ctrl_reg.brnch;
  assign alu_op     = ALUOP_W'(ctrl_reg.alu_op);
  assign wr_addr    = wr_addr_reg;
  assign illegal    = illegal_reg;
  assign perf_stall = perf_reg;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
module tb_decode_ctrl_pipe;

  localparam int LOAD_STALL = 1;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, flush, out_ready;
  logic [31:0] instr;
  logic        in_ready, out_valid;
  logic        alu_src, alu_src2, reg_sl, reg_dst, reg_write;
  logic        mem_read, mem_write, mem_to_reg, brnch, illegal;
  logic [3:0]  alu_op;
  logic [4:0]  wr_addr;
  logic [15:0] perf_stall;

  decode_ctrl_pipe #(.REG_AW(5), .ALUOP_W(4), .LOAD_STALL(LOAD_STALL), .PERF_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_src(alu_src), .alu_src2(alu_src2), .reg_sl(reg_sl), .reg_dst(reg_dst),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .brnch(brnch), .alu_op(alu_op), .wr_addr(wr_addr),
    .illegal(illegal), .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {illegal, alu_src, alu_src2, reg_sl, reg_dst, reg_write, mem_read,
  //  mem_write, mem_to_reg, brnch, alu_op[3:0], wr_addr[4:0]}
  logic [18:0] got_vec;
  assign got_vec = {illegal, alu_src, alu_src2, reg_sl, reg_dst, reg_write, mem_read,
                    mem_write, mem_to_reg, brnch, alu_op, wr_addr};

  function automatic logic [18:0] exp_bundle(input logic [31:0] w);
    logic [5:0] op, fn;
    logic [8:0] c;
    logic [3:0] a;
    logic       il;
    op = w[31:26]; fn = w[5:0]; c = '0; a = '0; il = 1'b0;
    if (op == 6'h00) begin
      c = 9'b000110000;
      if      (fn == 6'h20) a = 4'h0;
      else if (fn == 6'h22) a = 4'h1;
      else if (fn == 6'h24) a = 4'h3;
      else if (fn == 6'h25) a = 4'h4;
      else if (fn == 6'h2a) a = 4'h5;
      else if (fn == 6'h06) a = 4'hA;
      else if (fn == 6'h00) begin a = 4'h8; c = 9'b011110000; end
      else if (fn == 6'h02) begin a = 4'h9; c = 9'b011110000; end
      else il = 1'b1;
    end else if (op == 6'h1c) begin
      c = 9'b000110000;
      if      (fn == 6'h21) a = 4'hB;
      else if (fn == 6'h20) a = 4'hC;
      else if (fn == 6'h02) a = 4'h2;
      else il = 1'b1;
    end
    else if (op == 6'h08) c = 9'b100010000;
    else if (op == 6'h0d) begin c = 9'b100010000; a = 4'h4; end
    else if (op == 6'h23) c = 9'b100011010;
    else if (op == 6'h2b) c = 9'b100000100;
    else if (op == 6'h05) begin c = 9'b000100001; a = 4'h7; end
    else il = 1'b1;
    if (il) begin c = '0; a = '0; end
    return {il, c, a, (c[5] ? w[15:11] : w[20:16])};
  endfunction

  // {uses_rs, uses_rt}
  function automatic logic [1:0] exp_uses(input logic [31:0] w);
    logic [18:0] b;
    b = exp_bundle(w);
    if (b[18]) return 2'b00;
    if (w[31:26] == 6'h00 && (w[5:0] == 6'h00 || w[5:0] == 6'h02)) return 2'b01;
    if (w[31:26] == 6'h08 || w[31:26] == 6'h0d || w[31:26] == 6'h23) return 2'b10;
    return 2'b11;
  endfunction

  // Scoreboard plus cycle model of the handshake / hazard / counter.
  logic [18:0] sb_q[$];
  logic        m_ov;
  logic [1:0]  m_age;
  logic [4:0]  m_dest;
  logic [15:0] m_perf;

  always @(negedge clk) begin
    logic [1:0]  u;
    logic        haz, rdy, acc;
    logic [18:0] e;
    if (!rst_n) begin
      sb_q.delete();
      m_ov = 1'b0; m_age = 2'd0; m_dest = '0; m_perf = '0;
    end else begin
      u   = exp_uses(instr);
      haz = in_valid && m_age != 0 && m_dest != 0 &&
            ((u[1] && instr[25:21] == m_dest) || (u[0] && instr[20:16] == m_dest));
      rdy = !flush && !haz && (!m_ov || out_ready);
      acc = in_valid && rdy;
      chk("in_ready", 32'(in_ready), 32'(rdy));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("perf_stall", 32'(perf_stall), 32'(m_perf));
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("bundle", 32'(got_vec), 32'(e));
          $display("issue instr-bundle 0x%05h (exp 0x%05h)", got_vec, e);
        end
      end else if (flush && out_valid && sb_q.size() != 0) begin
        void'(sb_q.pop_front());
      end
      if (acc) sb_q.push_back(exp_bundle(instr));
      if (haz && m_perf != 16'hffff) m_perf = m_perf + 1'b1;
      if (flush) begin
        m_age = 2'd0;
      end else if (acc && instr[31:26] == 6'h23 && instr[20:16] != 0) begin
        m_dest = instr[20:16]; m_age = 2'(LOAD_STALL);
      end else if (m_age != 0 && (!m_ov || out_ready)) begin
        m_age = m_age - 2'd1;
      end
      if (flush) m_ov = 1'b0;
      else if (!(m_ov && !out_ready)) m_ov = acc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w);
    in_valid = v;
    instr    = w;
    #1;
  endtask

  logic [5:0] pool_op [14] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h1c,
                               6'h08, 6'h0d, 6'h23, 6'h23, 6'h2b, 6'h05, 6'h3f};
  logic [5:0] pool_fn [14] = '{6'h20, 6'h22, 6'h25, 6'h00, 6'h06, 6'h3f, 6'h21,
                               6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; instr = '0;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_bundle", 32'(got_vec), 32'd0);
    chk("rst_perf", 32'(perf_stall), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // 1: add $3,$1,$2
    drive(1'b1, 32'h00221820);
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    tick(); drive(1'b0, '0);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_alu_op", 32'(alu_op), 32'd0);
    chk("t1_reg_dst", 32'(reg_dst), 32'd1);
    chk("t1_wr_addr", 32'(wr_addr), 32'd3);
    tick();

    // 2: lw $5,0($1); add $6,$5,$2 -> one bubble
    drive(1'b1, 32'h8C250000);
    tick(); drive(1'b1, 32'h00A23020);
    chk("t2_stall_ready", 32'(in_ready), 32'd0);
    chk("t2_lw_valid", 32'(out_valid), 32'd1);
    tick();
    chk("t2_bubble", 32'(out_valid), 32'd0);
    chk("t2_perf", 32'(perf_stall), 32'd1);
    chk("t2_ready_after", 32'(in_ready), 32'd1);
    tick(); drive(1'b0, '0);
    chk("t2_add_valid", 32'(out_valid), 32'd1);
    chk("t2_add_wr", 32'(wr_addr), 32'd6);
    tick();

    // 3: lw $0 never creates a hazard
    drive(1'b1, 32'h8C200000);
    tick(); drive(1'b1, 32'h00023020);
    chk("t3_no_stall", 32'(in_ready), 32'd1);
    tick(); drive(1'b0, '0);
    chk("t3_add_valid", 32'(out_valid), 32'd1);
    chk("t3_add_wr", 32'(wr_addr), 32'd6);
    chk("t3_perf", 32'(perf_stall), 32'd1);
    tick();

    // 4: downstream stall holds the bundle for three cycles
    drive(1'b1, 32'h20070005);
    tick();
    out_ready = 1'b0; drive(1'b1, 32'h34080001);
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_valid", 32'(out_valid), 32'd1);
      chk("t4_hold_wr", 32'(wr_addr), 32'd7);
      chk("t4_hold_src", 32'(alu_src), 32'd1);
      chk("t4_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1; #1;
    chk("t4_release_ready", 32'(in_ready), 32'd1);
    tick(); drive(1'b0, '0);
    chk("t4_ori_wr", 32'(wr_addr), 32'd8);
    chk("t4_ori_op", 32'(alu_op), 32'd4);
    tick();

    // 5: flush with lw in flight and dependent sw waiting
    drive(1'b1, 32'h8C290004);
    tick();
    flush = 1'b1; drive(1'b1, 32'hAC490000);
    chk("t5_flush_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; #1;
    chk("t5_squashed", 32'(out_valid), 32'd0);
    chk("t5_no_bubble", 32'(in_ready), 32'd1);
    tick(); drive(1'b0, '0);
    chk("t5_sw_valid", 32'(out_valid), 32'd1);
    chk("t5_sw_memw", 32'(mem_write), 32'd1);
    chk("t5_perf", 32'(perf_stall), 32'd2);
    tick();

    // 6: illegal opcode, then async reset mid-stream
    drive(1'b1, 32'hFC000000);
    tick(); drive(1'b1, 32'h14220003);
    chk("t6_ill_valid", 32'(out_valid), 32'd1);
    chk("t6_illegal", 32'(illegal), 32'd1);
    chk("t6_ctrl", 32'({reg_write, mem_write, brnch}), 32'd0);
    tick();
    chk("t6_bne_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0; #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_bundle", 32'(got_vec), 32'd0);
    chk("t6_rst_perf", 32'(perf_stall), 32'd0);
    drive(1'b0, '0);
    tick();
    rst_n = 1'b1;
    tick();

    // Random mix with small register numbers to provoke load-use hazards.
    for (int c = 0; c < 400; c++) begin
      int k;
      k = int'($urandom_range(0, 13));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      drive(($urandom_range(0, 3) != 0),
            {pool_op[k], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), pool_fn[k]});
      tick();
    end
    flush = 1'b0; out_ready = 1'b1; drive(1'b0, '0);
    for (int c = 0; c < 5; c++) tick();
    chk("drain", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
